if_fetch_unit: RTL and testbench

- IF stage of the forwarding pipeline. Owns the PC, issues instruction-memory requests over a req/gnt + rvalid handshake, buffers returned instructions, and drives the IF/ID pipeline register.
- It is the consumer of the hazard unit's stall_pc, stall_if_id and flush_if_id outputs, and of the EX-stage branch redirect.
- Guarantees that no instruction is lost under a stall, and that no wrong-path instruction is delivered after a flush.

---
 rtl/if_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the forwarding pipeline. Owns the PC, issues
// instruction-memory requests over a req/gnt + rvalid handshake, buffers
// returned instructions and drives the IF/ID pipeline register.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_stall_pc            hold the PC, issue no new request
//   i_stall_if_id         hold the IF/ID register
//   i_flush_if_id         squash IF/ID and every in-flight fetch
//   i_branch_target       redirect PC, valid while i_flush_if_id=1
//   o_imem_req/o_imem_addr, i_imem_gnt          request channel
//   i_imem_rvalid/i_imem_rdata                   in-order response channel
//   o_valid_id/o_pc_id/o_instr_id                IF/ID register
//
// Outstanding requests are tracked in a tag queue of {pc, epoch}. Responses
// whose epoch differs from the current one belong to a squashed path and are
// dropped. A request is issued only while tag-queue plus response-FIFO
// occupancy is below DEPTH, so every response always has a FIFO slot.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_pc,
    input  logic        i_stall_if_id,
    input  logic        i_flush_if_id,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid_id,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_instr_id
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Architectural state
    logic [31:0]   pc_q, pc_d;
    logic          epoch_q, epoch_d;
    logic          valid_id_q, valid_id_d;
    logic [31:0]   pc_id_q, pc_id_d;
    logic [31:0]   instr_id_q, instr_id_d;

    // Tag queue of outstanding requests
    logic [31:0]   tag_pc_q [DEPTH];
    logic          tag_ep_q [DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    // Response FIFO of {pc, instr}
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [CW:0]   in_use;
    logic          req, fire;
    logic          resp_pop, resp_ok;
    logic          fifo_nonempty, load_en, fifo_pop, bypass, fifo_push;
    logic [31:0]   head_pc;

    assign in_use = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
    // Gated by reset so the bus sees no request while the block is held.
    assign req  = i_rst_n && !i_stall_pc && !i_flush_if_id && (in_use < DEPTH_W);
    assign fire = req && i_imem_gnt;

    assign head_pc  = tag_pc_q[tag_rd_q];
    // An rvalid with nothing outstanding is ignored.
    assign resp_pop = i_imem_rvalid && (out_cnt_q != '0);
    // Responses arriving in a flush cycle are wrong-path by definition.
    assign resp_ok  = resp_pop && (tag_ep_q[tag_rd_q] == epoch_q) && !i_flush_if_id;

    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign load_en       = !i_stall_if_id && !i_flush_if_id;
    assign fifo_pop      = load_en && fifo_nonempty;
    assign bypass        = load_en && !fifo_nonempty && resp_ok;
    assign fifo_push     = resp_ok && !bypass;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        valid_id_d = valid_id_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;

        tag_wr_d  = fire     ? tag_wr_q + PW'(1) : tag_wr_q;
        tag_rd_d  = resp_pop ? tag_rd_q + PW'(1) : tag_rd_q;
        out_cnt_d = out_cnt_q + CW'(fire) - CW'(resp_pop);

        fifo_wr_d  = fifo_push ? fifo_wr_q + PW'(1) : fifo_wr_q;
        fifo_rd_d  = fifo_pop  ? fifo_rd_q + PW'(1) : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);

        if (i_flush_if_id) begin
            // Tag-queue entries survive with the old epoch and drain as dropped.
            pc_d       = i_branch_target;
            epoch_d    = ~epoch_q;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
            valid_id_d = 1'b0;
            instr_id_d = NOP_INSTR;
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (load_en) begin
                if (fifo_nonempty) begin
                    valid_id_d = 1'b1;
                    pc_id_d    = fifo_pc_q[fifo_rd_q];
                    instr_id_d = fifo_instr_q[fifo_rd_q];
                end else if (resp_ok) begin
                    valid_id_d = 1'b1;
                    pc_id_d    = head_pc;
                    instr_id_d = i_imem_rdata;
                end else begin
                    valid_id_d = 1'b0;
                    instr_id_d = NOP_INSTR;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC;
            epoch_q    <= 1'b0;
            valid_id_q <= 1'b0;
            pc_id_q    <= '0;
            instr_id_q <= NOP_INSTR;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            out_cnt_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            valid_id_q <= valid_id_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            out_cnt_q  <= out_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // NOTE: storage arrays are not reset; the occupancy counters guard every read.
    always_ff @(posedge i_clk) begin
        if (fire) begin
            tag_pc_q[tag_wr_q] <= pc_q;
            tag_ep_q[tag_wr_q] <= epoch_q;
        end
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_q]    <= head_pc;
            fifo_instr_q[fifo_wr_q] <= i_imem_rdata;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = pc_q;
    assign o_valid_id  = valid_id_q;
    assign o_pc_id     = pc_id_q;
    assign o_instr_id  = instr_id_q;

    // A response with no outstanding request is a memory-side protocol error.
    rvalid_has_request: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(i_imem_rvalid && (out_cnt_q == '0))
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit: a directed vector table for the
// streaming/stall behaviour, hand-written flush, grant-stall, wrap and reset
// sequences, then random traffic against a queue-based reference model.
// The memory responder answers in order with rdata = addr + 0xA0.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst_n = 1'b1;
    logic        i_stall_pc = 1'b0;
    logic        i_stall_if_id = 1'b0;
    logic        i_flush_if_id = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid_id;
    logic [31:0] o_pc_id;
    logic [31:0] o_instr_id;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_stall_pc     (i_stall_pc),
        .i_stall_if_id  (i_stall_if_id),
        .i_flush_if_id  (i_flush_if_id),
        .i_branch_target(i_branch_target),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .o_valid_id     (o_valid_id),
        .o_pc_id        (o_pc_id),
        .o_instr_id     (o_instr_id)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (spec-level, queue based) ----------
    typedef struct { logic [31:0] pc; logic ep; } tag_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    tag_t        m_tags[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc;
    logic        m_ep;
    logic        m_valid;
    logic [31:0] m_pc_id, m_instr_id;

    // ---------------- memory responder ----------------------------------
    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t rsp_q[$];
    int   cyc;

    logic        last_req;
    logic [31:0] last_addr;

    task automatic model_reset();
        m_tags.delete();
        m_fifo.delete();
        m_pc       = RESET_PC;
        m_ep       = 1'b0;
        m_valid    = 1'b0;
        m_pc_id    = '0;
        m_instr_id = NOP;
    endtask

    // Called at a negedge; asserts reset, checks the asynchronous reset state,
    // then releases reset on a later negedge.
    task automatic do_reset();
        i_rst_n         = 1'b0;
        i_stall_pc      = 1'b0;
        i_stall_if_id   = 1'b0;
        i_flush_if_id   = 1'b0;
        i_branch_target = '0;
        i_imem_gnt      = 1'b1;
        i_imem_rvalid   = 1'b0;
        i_imem_rdata    = '0;
        #1;
        check("rst_req",   32'(o_imem_req), 32'd0);
        check("rst_valid", 32'(o_valid_id), 32'd0);
        check("rst_pc_id", o_pc_id, 32'd0);
        check("rst_instr", o_instr_id, NOP);
        repeat (2) @(negedge i_clk);
        check("rst_req_held", 32'(o_imem_req), 32'd0);
        check("rst_addr",     o_imem_addr, RESET_PC);
        rsp_q.delete();
        model_reset();
        cyc     = 0;
        i_rst_n = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check the request side before the
    // rising edge, advance the model, check IF/ID after the edge.
    task automatic tick(input logic spc, input logic sif, input logic fl,
                        input logic [31:0] tgt, input logic gnt, input int lat);
        logic        exp_req, rv, cand_ok, taken;
        logic [31:0] rd;
        tag_t        t;
        ent_t        e;
        t = '{32'd0, 1'b0};
        i_stall_pc      = spc;
        i_stall_if_id   = sif;
        i_flush_if_id   = fl;
        i_branch_target = tgt;
        i_imem_gnt      = gnt;
        rv = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
        rd = rv ? rsp_q[0].addr + 32'h0000_00A0 : 32'hDEAD_BEEF;
        i_imem_rvalid = rv;
        i_imem_rdata  = rd;
        #1;
        exp_req = !spc && !fl && ((m_tags.size() + m_fifo.size()) < DEPTH);
        check("imem_req", 32'(o_imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", o_imem_addr, m_pc);
        last_req  = o_imem_req;
        last_addr = o_imem_addr;
        if (o_imem_req && gnt) rsp_q.push_back('{o_imem_addr, cyc + lat});

        cand_ok = 1'b0;
        taken   = 1'b0;
        if (rv && m_tags.size() > 0) begin
            t = m_tags.pop_front();
            cand_ok = (t.ep == m_ep) && !fl;
        end
        if (exp_req && gnt) m_tags.push_back('{m_pc, m_ep});
        if (fl) begin
            m_fifo.delete();
            m_valid    = 1'b0;
            m_instr_id = NOP;
            m_pc       = tgt;
            m_ep       = ~m_ep;
        end else begin
            if (exp_req && gnt) m_pc = m_pc + 32'd4;
            if (!sif) begin
                if (m_fifo.size() > 0) begin
                    e = m_fifo.pop_front();
                    m_valid = 1'b1; m_pc_id = e.pc; m_instr_id = e.instr;
                end else if (cand_ok) begin
                    m_valid = 1'b1; m_pc_id = t.pc; m_instr_id = rd;
                    taken = 1'b1;
                end else begin
                    m_valid = 1'b0; m_instr_id = NOP;
                end
            end
            if (cand_ok && !taken) m_fifo.push_back('{t.pc, rd});
        end

        @(posedge i_clk);
        if (rv) void'(rsp_q.pop_front());
        cyc++;
        @(negedge i_clk);
        check("valid_id", 32'(o_valid_id), 32'(m_valid));
        check("pc_id",    o_pc_id,    m_pc_id);
        check("instr_id", o_instr_id, m_instr_id);
    endtask

    // ---------------- directed vector table -----------------------------
    typedef struct {
        logic        spc;
        logic        sif;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[19];

    initial begin
        // Streaming, then full stall for 3 cycles, then stall_if_id only
        // (credit exhaustion drops req), then resume.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h08};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0C};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0C};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h14};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h18};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1C};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1C};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1C};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1C};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h20};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h24};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h28};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h2C};

        #1;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            tick(vecs[i].spc, vecs[i].sif, 1'b0, 32'd0, 1'b1, 1);
            check($sformatf("vec%0d_req", i),   32'(last_req),   32'(vecs[i].exp_req));
            check($sformatf("vec%0d_valid", i), 32'(o_valid_id), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i),    o_pc_id,         vecs[i].exp_pc);
        end

        // Flush to 0x100 with two fetches in flight (rvalid 2 cycles late).
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
        check("inflight_before_flush", 32'(rsp_q.size()), 32'd2);
        tick(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 2);
        check("flush_bubble_valid", 32'(o_valid_id), 32'd0);
        check("flush_bubble_instr", o_instr_id, NOP);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
        check("flush_first_addr", last_addr, 32'h100);
        check("stale_drop_a", 32'(o_valid_id), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
        check("stale_drop_b", 32'(o_valid_id), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
        check("post_flush_valid", 32'(o_valid_id), 32'd1);
        check("post_flush_pc0",   o_pc_id, 32'h100);
        check("post_flush_instr", o_instr_id, 32'h1A0);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
        check("post_flush_pc1", o_pc_id, 32'h104);

        // Flush and stall_if_id together: flush wins.
        tick(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1);
        check("flush_stall_valid", 32'(o_valid_id), 32'd0);
        check("flush_stall_instr", o_instr_id, NOP);
        check("flush_cycle_no_req", 32'(last_req), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("flush_stall_addr", last_addr, 32'h40);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("flush_stall_pc", o_pc_id, 32'h40);

        // Grant held low for 4 cycles.
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1);
            check($sformatf("nognt%0d_req", i),  32'(last_req), 32'd1);
            check($sformatf("nognt%0d_addr", i), last_addr, 32'h4);
            if (i >= 2) check($sformatf("nognt%0d_drained", i), 32'(o_valid_id), 32'd0);
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("nognt_no_advance", last_addr, 32'h4);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("nognt_resume_pc", o_pc_id, 32'h4);

        // PC wrap at the top of the address space.
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("wrap_addr_top", last_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("wrap_addr_zero", last_addr, 32'h0);
        check("wrap_pc_top",    o_pc_id, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("wrap_pc_zero", o_pc_id, 32'h0);

        // Reset mid-stream with responses outstanding.
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 3);
        check("midrst_outstanding", 32'(rsp_q.size() > 0), 32'd1);
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
        check("midrst_first_req",  32'(last_req), 32'd1);
        check("midrst_first_addr", last_addr, RESET_PC);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 7,
                 int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
